multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//  Sequential successor to the combinational control decoder. Accepts one instruction per
//  valid/ready handshake and latches its op/inst/imm fields. Steps through EXEC, optional
//  MEM and WB states, emitting one-cycle control strobes. Waits on a memory-ready handshake
//  with timeout. Sits between instruction fetch and the datapath (ALU, extender, memory, PC).
// PARAMETERS
//  INST_W       2   width of inst sub-opcode field (>=2)
//  ALU_W        3   width of alu_sel output
//  MEM_TIMEOUT  15  max cycles waited in MEM for mem_ready (>=1)
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  instr_valid  in   1        instruction fields valid
//  instr_ready  out  1        unit can accept (high only in IDLE, low while flush=1)
//  op           in   2        class: 00 jump, 01 reserved/nop, 10 memory, 11 ALU
//  inst         in   INST_W   sub-opcode
//  immin        in   1        immediate-operand flag
//  flush        in   1        abort current instruction
//  mem_ready    in   1        memory completed request
//  immout       out  1        latched imm flag, valid in EXEC
//  alu_sel      out  ALU_W    {inst,imm} zero-extended/truncated to ALU_W, valid in EXEC
//  ext_sel      out  2        op==00 -> 2'b11 else inst[1:0], valid in EXEC
//  jmp          out  1        EXEC strobe, op==00
//  wpc          out  1        EXEC strobe, inst==0
//  wmem         out  1        held in MEM, op==10 & inst==0 & !imm
//  rmem         out  1        held in MEM, op==10 & inst==1 & !imm
//  wreg         out  1        WB strobe, op==11 | (op==10 & inst!=all-ones); suppressed on timeout
//  busy         out  1        state != IDLE
//  timeout_err  out  1        sticky; set on MEM timeout, cleared by rst or next accept
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, instr_ready=1 the cycle after rst deasserts; latched fields 0.
//  - Accept when instr_valid & instr_ready; fields latched; all decodes derived from latched regs.
//  - States: IDLE -> EXEC -> (MEM if wmem|rmem decode) -> WB -> IDLE.
//  - ALU/jump op accepted at cycle T: EXEC T+1, WB T+2, instr_ready high at T+3.
//  - MEM: wmem/rmem held, timeout counter starts at 0; mem_ready -> WB next cycle.
//  - Counter reaches MEM_TIMEOUT without mem_ready -> set timeout_err; go to WB with wreg=0.
//  - mem_ready on the same cycle the counter hits MEM_TIMEOUT: counts as success, no error.
//  - mem_ready outside MEM is ignored.
//  - Strobes are Moore outputs, 0 in every state other than their own.
//  - op==10 with imm=1 decodes neither wmem nor rmem: no MEM state, wreg per rule above.
//  - flush: next state IDLE, strobes 0 the following cycle; no effect in IDLE except blocking accept.
//  - Priority: rst > flush > mem_ready/timeout > accept.
// CONFIGURATION
//  CU_PERF_CNT_EN defined: adds output retired_cnt[31:0], reset 0.
//    Increments on each WB->IDLE exit; flushed instructions excluded; wraps at 2^32.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package cu_pkg: state enum {IDLE,EXEC,MEM,WB}, op-class constants OP_JMP/OP_NOP/OP_MEM/OP_ALU,
//    EXT_WIDE=2'b11.
//  Sub-module cu_field_decode: pure combinational latched-fields -> control vector, reused by the FSM.
// TESTING
//  1. ALU op=11 inst=10 imm=1, ALU_W=3: alu_sel=3'b101 in T+1, wreg=1 T+2 only, instr_ready T+3.
//  2. Store op=10 inst=00 imm=0, mem_ready after 4 cycles: wmem high 4 cycles, wreg pulse, no error.
//  3. Load op=10 inst=01 imm=0, mem_ready never: after 15 MEM cycles timeout_err=1, wreg stays 0.
//  4. Jump op=00 inst=00: T+1 jmp=1, wpc=1, ext_sel=2'b11; no MEM; wreg=0.
//  5. flush asserted during MEM of a load: next cycle IDLE, rmem=0, no wreg; retired_cnt unchanged.
//  6. rst mid-EXEC, then back-to-back valid: outputs 0 after rst; 2nd instr accepted only in IDLE.

Source files
------------

// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cu_pkg
// Brief   : Shared types and constants for the multicycle control unit:
//           FSM state encoding, op-class codes and the decoded control vector.
// Revision: 1.0  initial release
// ============================================================================
package cu_pkg;

  // Instruction lifecycle states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MEM  = 2'd2,
    WB   = 2'd3
  } cu_state_e;

  // Instruction classes carried on the op field
  localparam logic [1:0] OP_JMP = 2'b00;
  localparam logic [1:0] OP_NOP = 2'b01;
  localparam logic [1:0] OP_MEM = 2'b10;
  localparam logic [1:0] OP_ALU = 2'b11;

  // Extender select used by jumps (widest immediate form)
  localparam logic [1:0] EXT_WIDE = 2'b11;

  // Control vector derived purely from the latched instruction fields
  typedef struct packed {
    logic       jmp;
    logic       wpc;
    logic       wmem;
    logic       rmem;
    logic       wreg;
    logic [1:0] ext_sel;
  } cu_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/cu_field_decode.sv
`default_nettype none
// ============================================================================
// Module  : cu_field_decode
// Brief   : Pure combinational decode of the latched op/inst/imm fields into
//           the control vector and ALU select used by the control FSM.
// Revision: 1.0  initial release
// ============================================================================
module cu_field_decode
  import cu_pkg::*;
#(
  parameter int INST_W = 2,
  parameter int ALU_W  = 3
) (
  input  logic [1:0]        op,
  input  logic [INST_W-1:0] inst,
  input  logic              imm,
  output cu_ctrl_t          ctrl,
  output logic [ALU_W-1:0]  alu_sel
);

  localparam int CAT_W = INST_W + 1;

  logic [CAT_W-1:0] w_cat;
  assign w_cat = {inst, imm};

  // ALU select is {inst,imm}, zero-extended or truncated to the output width
  generate
    if (ALU_W > CAT_W) begin : g_alu_zext
      assign alu_sel = {{(ALU_W-CAT_W){1'b0}}, w_cat};
    end else if (ALU_W == CAT_W) begin : g_alu_exact
      assign alu_sel = w_cat;
    end else begin : g_alu_trunc
      assign alu_sel = w_cat[ALU_W-1:0];
    end
  endgenerate

  // Per-class control decode; memory strobes require a register (non-imm) form
  always_comb begin
    ctrl         = '0;
    ctrl.jmp     = (op == OP_JMP);
    ctrl.wpc     = (inst == '0);
    ctrl.wmem    = (op == OP_MEM) && (inst == INST_W'(0)) && !imm;
    ctrl.rmem    = (op == OP_MEM) && (inst == INST_W'(1)) && !imm;
    ctrl.wreg    = (op == OP_ALU) || ((op == OP_MEM) && (inst != '1));
    ctrl.ext_sel = (op == OP_JMP) ? EXT_WIDE : inst[1:0];
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_control_unit
// Brief   : Sequential control unit. Accepts one instruction per valid/ready
//           handshake, then walks EXEC -> (MEM) -> WB emitting one-cycle
//           Moore control strobes. MEM waits on mem_ready with a timeout.
//           Optional macro CU_PERF_CNT_EN adds a retired-instruction counter.
// Revision: 1.0  initial release
// ============================================================================
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int INST_W      = 2,
  parameter int ALU_W       = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        op,
  input  logic [INST_W-1:0] inst,
  input  logic              immin,
  input  logic              flush,
  input  logic              mem_ready,
  output logic              immout,
  output logic [ALU_W-1:0]  alu_sel,
  output logic [1:0]        ext_sel,
  output logic              jmp,
  output logic              wpc,
  output logic              wmem,
  output logic              rmem,
  output logic              wreg,
  output logic              busy,
  output logic              timeout_err
`ifdef CU_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt
`endif
);

  // Counter holds the index of the current MEM cycle (0 .. MEM_TIMEOUT-1);
  // the last allowed MEM cycle is the one where it equals CNT_LAST.
  localparam int              CNT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  cu_state_e         state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              imm_q, imm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_err_q, timeout_err_d;

  cu_ctrl_t          w_ctrl;
  logic [ALU_W-1:0]  w_alu_sel;
  logic              w_accept;
  logic              w_mem_last;
  logic              w_mem_expire;

  cu_field_decode #(
    .INST_W (INST_W),
    .ALU_W  (ALU_W)
  ) u_decode (
    .op      (op_q),
    .inst    (inst_q),
    .imm     (imm_q),
    .ctrl    (w_ctrl),
    .alu_sel (w_alu_sel)
  );

  assign w_accept     = instr_valid && instr_ready;
  assign w_mem_last   = (state_q == MEM) && (cnt_q == CNT_LAST);
  // mem_ready on the final cycle wins over the timeout
  assign w_mem_expire = w_mem_last && !mem_ready;
  assign timeout_err  = timeout_err_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides everything except reset
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (w_accept) state_d = EXEC;
        EXEC:    state_d = (w_ctrl.wmem || w_ctrl.rmem) ? MEM : WB;
        MEM:     if (mem_ready || w_mem_last) state_d = WB;
        WB:      state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore outputs: each strobe only in its own state, qualifiers from latched fields
  always_comb begin
    instr_ready = (state_q == IDLE) && !flush && !rst;
    busy        = (state_q != IDLE);
    immout      = 1'b0;
    alu_sel     = '0;
    ext_sel     = 2'b00;
    jmp         = 1'b0;
    wpc         = 1'b0;
    wmem        = 1'b0;
    rmem        = 1'b0;
    wreg        = 1'b0;
    case (state_q)
      EXEC: begin
        immout  = imm_q;
        alu_sel = w_alu_sel;
        ext_sel = w_ctrl.ext_sel;
        jmp     = w_ctrl.jmp;
        wpc     = w_ctrl.wpc;
      end
      MEM: begin
        wmem = w_ctrl.wmem;
        rmem = w_ctrl.rmem;
      end
      WB: begin
        // a timed-out access must not write back
        wreg = w_ctrl.wreg && !timeout_err_q;
      end
      default: ;
    endcase
  end

  // Field latch, MEM wait counter and sticky timeout flag
  always_comb begin
    op_d          = op_q;
    inst_d        = inst_q;
    imm_d         = imm_q;
    timeout_err_d = timeout_err_q;
    cnt_d         = (state_q == MEM) ? cnt_q + 1'b1 : '0;
    if (w_accept) begin
      op_d          = op;
      inst_d        = inst;
      imm_d         = immin;
      timeout_err_d = 1'b0;
    end else if (!flush && w_mem_expire) begin
      timeout_err_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q          <= '0;
      inst_q        <= '0;
      imm_q         <= 1'b0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      op_q          <= op_d;
      inst_q        <= inst_d;
      imm_q         <= imm_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef CU_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;

  assign retired_cnt = retired_q;

  // Count completed write-back exits; a flush in WB discards the instruction
  always_comb begin
    retired_d = retired_q;
    if ((state_q == WB) && !flush) retired_d = retired_q + 32'd1;
  end

  // Retired-instruction counter register
  always_ff @(posedge clk) begin
    if (rst) retired_q <= '0;
    else     retired_q <= retired_d;
  end
`endif

endmodule
`default_nettype wire
